gat_feat_stream_reader: RTL and testbench
=========================================

// Module: gat_feat_stream_reader
// PURPOSE
// - Drains the new-feature BRAM read port (feat_bram_addrb / feat_bram_dout) of the GAT top after a layer completes.
// - Streams the words to the PS-side DMA as AXI4-Stream with TLAST on the final word.
// - Sits directly downstream of the GAT top. It is started from the gat_ready rising edge by the control logic.
// - Read latency is hidden with a credit-limited pipeline plus a show-ahead FIFO, so it sustains 1 word/cycle.
// PARAMETERS
// - NEW_FEATURE_WIDTH   32             : feature word width (BRAM dout and TDATA)
// - NEW_FEATURE_DEPTH   43328          : max words per layer (NUM_SUBGRAPHS*NUM_FEATURE_OUT)
// - NEW_FEATURE_ADDR_W  $clog2(DEPTH)  : word-address width
// - RD_LATENCY          2              : BRAM addrb->dout cycles (1..4)
// - FIFO_DEPTH          4              : output FIFO entries, power of 2, >= RD_LATENCY+2
// PORTS
// - clk               in   1                      : clock, all logic rising-edge
// - rst               in   1                      : asynchronous reset, active-high
// - start             in   1                      : 1-cycle pulse, begin a drain; ignored while busy
// - num_words         in   NEW_FEATURE_ADDR_W+1   : words to drain, latched on accepted start
// - busy              out  1                      : high from accepted start until done
// - done              out  1                      : 1-cycle pulse after the last beat handshakes
// - feat_bram_addrb   out  NEW_FEATURE_ADDR_W+2   : byte address, = word_idx<<2, bits[1:0]=0
// - feat_bram_dout    in   NEW_FEATURE_WIDTH      : BRAM data, valid RD_LATENCY cycles after addrb
// - m_axis_tdata      out  NEW_FEATURE_WIDTH      : stream data
// - m_axis_tvalid     out  1                      : stream valid
// - m_axis_tready     in   1                      : stream ready
// - m_axis_tlast      out  1                      : high on beat num_words-1 only
// BEHAVIOUR
// - Reset: all outputs are 0 (busy, done, addrb, tdata, tvalid, tlast). Clears the FSM, counters, FIFO and the in-flight shift register.
// - FSM states and transitions:
//   - IDLE -> RUN on start when num_words != 0.
//   - IDLE -> DONE on start when num_words == 0. No beat and no BRAM read are issued.
//   - RUN -> DRAIN when the issue count reaches num_words.
//   - DRAIN -> DONE when the last beat handshakes.
//   - DONE -> IDLE after 1 cycle. done=1 only while in DONE.
// - busy = (state != IDLE) && (state != DONE).
// - Issue rule: a read is issued in RUN when fifo_count + inflight < FIFO_DEPTH.
//   - Issuing drives addrb = rd_idx<<2 that cycle and increments rd_idx.
//   - inflight is the count of 1s in an RD_LATENCY-deep valid shift register.
// - addrb holds its last value when no read is issued. It returns to 0 on a new start.
// - Capture: when the shift-register tail is 1, feat_bram_dout is written to the FIFO. A credit is never violated, so the FIFO never overflows.
// - Output: show-ahead FIFO. tvalid = !empty and tdata = FIFO head.
//   - A pop occurs on tvalid && tready.
//   - tdata/tlast hold stable while tvalid=1 and tready=0 (AXI rule).
// - tlast: a beat counter (0..num_words-1) counts handshakes. tlast = tvalid && (beat_cnt == num_words-1).
// - Latency (start accepted in cycle 0, tready=1):
//   - first addrb issued in cycle 1;
//   - first tvalid in cycle 2+RD_LATENCY;
//   - then 1 beat per cycle;
//   - done in the cycle after the last handshake.
// - Simultaneous FIFO write and pop in the same cycle: count unchanged. A write into an empty FIFO becomes visible on tvalid the next cycle.
// - Backpressure: tready=0 stops issue once credits are exhausted. There is no data loss and no duplicate.
// - start while busy or in DONE is ignored. num_words is not re-latched.
// - num_words > NEW_FEATURE_DEPTH is clamped to NEW_FEATURE_DEPTH at latch.
// - Reset mid-operation: immediate return to IDLE.
//   - tvalid drops asynchronously and BRAM data still in flight is discarded.
//   - There is no done pulse.
// TESTING
// - T1, num_words=32, tready=1, BRAM model RD_LATENCY=2 with dout=word_idx:
//   -> 32 beats, tdata 0..31, tlast only on beat 31;
//   -> first tvalid 4 cycles after start; done 1 cycle after beat 31.
// - T2, num_words=20, tready toggling 1-0-0-1 pseudo-random:
//   -> exactly 20 in-order beats;
//   -> tdata/tlast stable under stall;
//   -> addrb never issued while fifo_count+inflight == 4.
// - T3, num_words=0 -> done pulse 1 cycle after start; zero tvalid; addrb unchanged from 0.
// - T4, start re-pulsed at beat 5 of a 16-word drain -> ignored; still 16 beats, single done.
// - T5, rst asserted during beat 7 of 16, then a new start with num_words=3:
//   -> tvalid=0 during rst;
//   -> next drain outputs tdata 0,1,2 from addrb 0x0,0x4,0x8 with tlast on the 3rd beat.
// - T6, num_words=1 with tready=0 held for 10 cycles:
//   -> a single beat with tvalid and tlast both high, held through the stall; done after it handshakes.

Source files
------------

// File: rtl/gat_feat_stream_reader.sv
// gat_feat_stream_reader
// Reads a finished layer out of the GAT new-feature BRAM (read port B) and
// streams it to the DMA as AXI4-Stream. TLAST is set on the final word. A
// credit-limited read pipeline feeds a small show-ahead FIFO, so the stream
// runs at one word per cycle even though the BRAM has read latency.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   start, num_words  : begin a drain of num_words words (ignored while busy/done)
//   busy, done        : drain in progress / 1-cycle completion pulse
//   feat_bram_addrb   : BRAM byte address (word index << 2)
//   feat_bram_dout    : BRAM read data, RD_LATENCY cycles after addrb
//   m_axis_*          : AXI4-Stream master (tdata, tvalid, tready, tlast)
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start
// RUN    | issuing BRAM reads, limited by FIFO credits
// DRAIN  | all reads issued, emptying pipeline and FIFO
// DONE   | one-cycle done pulse, then back to IDLE
module gat_feat_stream_reader #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NEW_FEATURE_DEPTH  = 43328,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int RD_LATENCY         = 2,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NEW_FEATURE_ADDR_W:0]     num_words,
  output logic                            busy,
  output logic                            done,
  output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]    feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]    m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);

  localparam int AW    = NEW_FEATURE_ADDR_W;
  localparam int NW_W  = NEW_FEATURE_ADDR_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [NW_W-1:0]  DEPTH_CLAMP = NW_W'(NEW_FEATURE_DEPTH);
  localparam logic [CNT_W-1:0] CREDITS     = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [NW_W-1:0]              issue_left;   // reads still to issue
  logic [NW_W-1:0]              last_idx;     // beat index that carries tlast
  logic [NW_W-1:0]              beat_cnt;
  logic [AW-1:0]                rd_idx;
  logic [AW+1:0]                addr_hold;
  logic [AW+1:0]                addr_issue;
  logic [RD_LATENCY-1:0]        vld_sr;       // reads in flight inside the BRAM
  logic [CNT_W-1:0]             inflight;
  logic [NEW_FEATURE_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [CNT_W-1:0]             fifo_count;
  logic [NW_W-1:0]              nw_clamped;

  logic start_ok, issue, capture, pop, last_beat;

  assign nw_clamped = (num_words > DEPTH_CLAMP) ? DEPTH_CLAMP : num_words;
  assign capture    = vld_sr[RD_LATENCY-1];

  assign m_axis_tvalid = (fifo_count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[rd_ptr] : '0;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign last_beat     = (beat_cnt == last_idx);
  assign m_axis_tlast  = m_axis_tvalid && last_beat;

  assign addr_issue      = {rd_idx, 2'b00};
  assign feat_bram_addrb = issue ? addr_issue : addr_hold;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + {{(CNT_W-1){1'b0}}, vld_sr[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    issue    = 1'b0;
    start_ok = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = (num_words == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        // Reads in flight already own a FIFO slot, so the FIFO cannot overflow.
        issue = ((fifo_count + inflight) < CREDITS);
        if (issue && (issue_left == NW_W'(1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (pop && last_beat) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_left <= '0;
      last_idx   <= '0;
      beat_cnt   <= '0;
      rd_idx     <= '0;
      addr_hold  <= '0;
      vld_sr     <= '0;
    end else begin
      if (start_ok) begin
        issue_left <= nw_clamped;
        last_idx   <= nw_clamped - NW_W'(1);
        beat_cnt   <= '0;
        rd_idx     <= '0;
        addr_hold  <= '0;
      end else begin
        if (issue) begin
          issue_left <= issue_left - NW_W'(1);
          rd_idx     <= rd_idx + AW'(1);
          addr_hold  <= addr_issue;
        end
        if (pop) begin
          beat_cnt <= beat_cnt + NW_W'(1);
        end
      end
      vld_sr[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Data storage needs no reset; tdata is gated while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (capture) begin
      fifo_mem[wr_ptr] <= feat_bram_dout;
    end
  end

endmodule

// File: tb/tb_gat_feat_stream_reader.sv
module tb_gat_feat_stream_reader;

  localparam int W     = 32;
  localparam int DEPTH = 43328;
  localparam int AW    = $clog2(DEPTH);
  localparam int RDL   = 2;
  localparam int FD    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW:0]     num_words;
  logic            busy, done;
  logic [AW+1:0]   addrb;
  logic [W-1:0]    dout;
  logic [W-1:0]    tdata;
  logic            tvalid, tready, tlast;

  always #5 clk = ~clk;

  gat_feat_stream_reader #(
    .NEW_FEATURE_WIDTH (W),
    .NEW_FEATURE_DEPTH (DEPTH),
    .NEW_FEATURE_ADDR_W(AW),
    .RD_LATENCY        (RDL),
    .FIFO_DEPTH        (FD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_words      (num_words),
    .busy           (busy),
    .done           (done),
    .feat_bram_addrb(addrb),
    .feat_bram_dout (dout),
    .m_axis_tdata   (tdata),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tlast   (tlast)
  );

  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] data_key = '0;

  function automatic logic [W-1:0] word_of(input int idx);
    return W'(idx) ^ data_key;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // BRAM: fixed read latency, contents are a keyed function of the word index.
  logic [W-1:0] pipe [RDL];
  always @(posedge clk) begin
    pipe[0] <= word_of(int'(addrb >> 2));
    for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
  end
  assign dout = pipe[RDL-1];

  // Reference model: a drain of n words must deliver word_of(0..n-1) in order,
  // tlast on the last one, done the cycle after the last handshake.
  bit        m_active = 0, m_done = 0;
  int        m_n = 0, m_beat = 0;
  bit        prev_stall = 0;
  logic [W-1:0] prev_data;
  logic      prev_last;
  int        cyc = 0, start_cyc = 0, done_cyc = 0, lat = -1;
  int        hs_count = 0, done_count = 0;

  always @(negedge clk) begin
    bit accept, next_done;
    int addr_idx;
    if (rst) begin
      chk("rst_tvalid", tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tlast", tlast, 0);
      m_active = 0; m_done = 0; m_beat = 0; prev_stall = 0;
    end else begin
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      if (tvalid) begin
        chk("valid_only_when_busy", 1'b1, m_active);
        chk("tdata", tdata, word_of(m_beat));
        chk("tlast", tlast, (m_beat == m_n - 1));
        if (lat < 0) lat = cyc - start_cyc;
      end else begin
        chk("tlast_no_valid", tlast, 0);
      end
      if (prev_stall) begin
        chk("stall_tvalid", tvalid, 1);
        chk("stall_tdata", tdata, prev_data);
        chk("stall_tlast", tlast, prev_last);
      end
      if (m_active) begin
        addr_idx = int'(addrb >> 2);
        chk("addrb_align", addrb[1:0], 0);
        chk("credit", (addr_idx + 1 <= m_beat + FD), 1);
      end
      accept = start && !m_active && !m_done;
      next_done = 0;
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (tvalid && tready) begin
        hs_count++;
        m_beat++;
        if (m_beat == m_n) begin
          m_active = 0;
          next_done = 1;
        end
      end
      if (accept) begin
        m_n = (int'(num_words) > DEPTH) ? DEPTH : int'(num_words);
        m_beat = 0;
        start_cyc = cyc;
        lat = -1;
        if (m_n == 0) next_done = 1;
        else m_active = 1;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
      m_done = next_done;
    end
    cyc++;
  end

  function automatic logic ready_for(input int mode, input int k, input int stall);
    if (mode == 1) return logic'($urandom_range(0, 1));
    if (mode == 2) return (k >= stall);
    return 1'b1;
  endfunction

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // rep >= 0 : re-pulse start once beat rep is reached; rstb >= 0 : reset at beat rstb
  task automatic run_drain(input int n, input int rep, input int rstb,
                           input int mode, input int stall);
    int hs0, d0, budget;
    bit pulsed, got_done;
    hs0 = hs_count; d0 = done_count;
    budget = 4 * n + stall + 100;
    pulsed = 0; got_done = 0;
    @(posedge clk); #1;
    num_words = (AW+1)'(n);
    start = 1'b1;
    tready = ready_for(mode, 0, stall);
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      tready = ready_for(mode, k, stall);
      if (n == 0) chk("zero_addrb", addrb, 0);
      if (rep >= 0 && !pulsed && (hs_count - hs0) == rep) begin
        start = 1'b1;
        num_words = (AW+1)'(7);
        pulsed = 1;
      end
      if (rstb >= 0 && (hs_count - hs0) == rstb) begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_cut_beats", hs_count - hs0, rstb);
        chk("rst_no_done", done_count - d0, 0);
        return;
      end
      if (done_count != d0) begin
        got_done = 1;
        break;
      end
    end
    chk("done_seen", got_done, 1);
    tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("beats", hs_count - hs0, n);
    chk("single_done", done_count - d0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_words = '0; tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addrb", addrb, 0);
    chk("rst_tdata", tdata, 0);
    @(posedge clk); #1 rst = 1'b0;

    // T1: dout = word index, full rate
    data_key = '0;
    run_drain(32, -1, -1, 0, 0);
    chk("t1_first_valid", lat, 2 + RDL);
    chk("t1_done_cycle", done_cyc - start_cyc, 2 + RDL + 32);

    // T2: random backpressure
    data_key = $urandom;
    run_drain(20, -1, -1, 1, 0);

    // T3: zero-length drain from reset
    do_reset(2);
    run_drain(0, -1, -1, 0, 0);
    chk("t3_done_cycle", done_cyc - start_cyc, 1);

    // T4: start re-pulsed mid-drain
    data_key = $urandom;
    run_drain(16, 5, -1, 0, 0);

    // T5: reset at beat 7, then a fresh 3-word drain
    data_key = $urandom;
    run_drain(16, -1, 7, 0, 0);
    data_key = $urandom;
    run_drain(3, -1, -1, 0, 0);
    chk("t5_first_valid", lat, 2 + RDL);

    // T6: single word stalled for 10 cycles
    data_key = $urandom;
    run_drain(1, -1, -1, 2, 10);
    chk("t6_done_cycle", done_cyc - start_cyc, 11);

    repeat (8) begin
      data_key = $urandom;
      run_drain(int'($urandom_range(1, 40)), -1, -1, int'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
